// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/byte_ram.sv
// Byte-lane RAM: two 4-lane word read ports, one byte read port, one 4-lane word write port.
// Latency: reads combinational; write lands on the rising edge.
// Backpressure: none; every request is served the same cycle.
module byte_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-3:0]     wr_word,
    input  logic [BYTE_W-1:0]     wr_data [0:LANES-1],
    input  logic [ADDR_W-3:0]     ra_word,
    output logic [BYTE_W-1:0]     ra_data [0:LANES-1],
    input  logic [ADDR_W-3:0]     rb_word,
    output logic [BYTE_W-1:0]     rb_data [0:LANES-1],
    input  logic [ADDR_W-1:0]     rc_addr,
    output logic [BYTE_W-1:0]     rc_data
);

    // Contents survive reset on purpose, so there is no reset here.
    logic [BYTE_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Word write: lane k lands at byte k of the addressed word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                mem[{wr_word, k[1:0]}] <= wr_data[k];
            end
        end
    end

    // Combinational reads; a same-cycle write is not yet visible here.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            ra_data[k] = mem[{ra_word, k[1:0]}];
            rb_data[k] = mem[{rb_word, k[1:0]}];
        end
        rc_data = mem[rc_addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Core memory responder: word reads/writes, then a post-halt byte dump stream.
// Latency: reads 0 cycles; writes visible after the edge; first dump byte one edge after halt.
// Backpressure: dump_ready low holds the current dump byte and address stable.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_BYTES = 256
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [31:0]           inst_addr,
    output logic [31:0]           inst,
    input  logic [31:0]           mem_addr,
    input  logic [BYTE_W-1:0]     mem_data_in  [0:LANES-1],
    output logic [BYTE_W-1:0]     mem_data_out [0:LANES-1],
    input  logic                  mem_write_en,
    input  logic                  halted,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_W-1:0]     dump_addr,
    output logic [BYTE_W-1:0]     dump_data,
    output logic                  dump_done
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DUMP_BYTES - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              wr_en;
    logic [BYTE_W-1:0] inst_bytes [0:LANES-1];
    logic [BYTE_W-1:0] rc_data;
    logic [ADDR_W-1:0] rc_addr;

    // Byte-offset and out-of-range address bits are deliberately dropped (aligned, wrapping).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:ADDR_W], inst_addr[1:0],
                                mem_addr[31:ADDR_W], mem_addr[1:0]};

    // Writes only land while the core is running and no dump has started.
    assign wr_en   = mem_write_en && (state_q == IDLE) && !halted;
    assign rc_addr = BASE + cnt_q;

    byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_word (mem_addr[ADDR_W-1:2]),
        .wr_data (mem_data_in),
        .ra_word (inst_addr[ADDR_W-1:2]),
        .ra_data (inst_bytes),
        .rb_word (mem_addr[ADDR_W-1:2]),
        .rb_data (mem_data_out),
        .rc_addr (rc_addr),
        .rc_data (rc_data)
    );

    // Instruction word is assembled little-endian.
    assign inst = {inst_bytes[3], inst_bytes[2], inst_bytes[1], inst_bytes[0]};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: halt starts the dump once; DONE only exits via reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (halted) state_d = DUMP;
            DUMP:    if (dump_ready && (cnt_q == LAST)) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Dump counter: parked at 0 in IDLE, advances on each accepted byte.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if ((state_q == DUMP) && dump_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // FSM outputs: dump address/data forced to zero whenever nothing is offered.
    always_comb begin
        dump_valid = (state_q == DUMP);
        dump_done  = (state_q == DONE);
        dump_addr  = dump_valid ? rc_addr : '0;
        dump_data  = dump_valid ? rc_data : '0;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a 4-byte dump window at 0x100.
// Latency: n/a.
// Backpressure: dump_ready is driven from a fixed stall pattern.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in  [0:3];
    logic [7:0]  mem_data_out [0:3];
    logic        mem_write_en;
    logic        halted;
    logic        dump_valid;
    logic        dump_ready;
    logic [15:0] dump_addr;
    logic [7:0]  dump_data;
    logic        dump_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(16), .DUMP_BASE(32'h100), .DUMP_BYTES(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .inst_addr    (inst_addr),
        .inst         (inst),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .halted       (halted),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .dump_done    (dump_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wdata(input logic [7:0] b0, b1, b2, b3);
        mem_data_in[0] = b0;
        mem_data_in[1] = b1;
        mem_data_in[2] = b2;
        mem_data_in[3] = b3;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [7:0] b0, b1, b2, b3);
        mem_addr = a;
        set_wdata(b0, b1, b2, b3);
        mem_write_en = 1'b1;
        tick();
        mem_write_en = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       pat   [0:4];
        logic [7:0] exp_b [0:3];
        int         exp_cnt;
        pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst_b = 1'b0; halted = 1'b0; dump_ready = 1'b0; mem_write_en = 1'b0;
        inst_addr = 32'h0; mem_addr = 32'h0;
        set_wdata(8'h0, 8'h0, 8'h0, 8'h0);
        #12;
        rst_b = 1'b1;
        tick();

        // Reset state.
        check_eq("rst_valid", {31'b0, dump_valid}, 32'h0);
        check_eq("rst_done",  {31'b0, dump_done},  32'h0);
        check_eq("rst_data",  {24'b0, dump_data},  32'h0);
        check_eq("rst_addr",  {16'b0, dump_addr},  32'h0);

        // Seed 0x100, then overwrite: same-cycle read must still see the seed.
        write_word(32'h100, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        mem_addr = 32'h102;
        set_wdata(8'h11, 8'h22, 8'h33, 8'h44);
        mem_write_en = 1'b1;
        #1;
        check_eq("rd_old_l0", {24'b0, mem_data_out[0]}, 32'hA0);
        check_eq("rd_old_l3", {24'b0, mem_data_out[3]}, 32'hA3);
        tick();
        mem_write_en = 1'b0;
        mem_addr = 32'h100;
        #1;
        check_eq("rd_l0", {24'b0, mem_data_out[0]}, 32'h11);
        check_eq("rd_l1", {24'b0, mem_data_out[1]}, 32'h22);
        check_eq("rd_l2", {24'b0, mem_data_out[2]}, 32'h33);
        check_eq("rd_l3", {24'b0, mem_data_out[3]}, 32'h44);
        inst_addr = 32'h100;
        #1;
        check_eq("inst_100", inst, 32'h44332211);
        inst_addr = 32'h0001_0103;
        #1;
        check_eq("inst_alias", inst, 32'h44332211);

        // Upper address bits wrap.
        write_word(32'h0001_0008, 8'h05, 8'h06, 8'h07, 8'h08);
        inst_addr = 32'h8;
        #1;
        check_eq("wrap_inst", inst, 32'h08070605);

        // Known word at 0, then a halted write of 0xFF must be dropped.
        write_word(32'h0, 8'h04, 8'h03, 8'h02, 8'h01);
        halted = 1'b1;
        write_word(32'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        inst_addr = 32'h0;
        #1;
        check_eq("blk_inst", inst, 32'h01020304);

        // Dump already entered on that edge; walk the stall pattern.
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            dump_ready = pat[i];
            if (i == 1) begin
                halted = 1'b0;
                mem_addr = 32'h100;
                set_wdata(8'hEE, 8'hEE, 8'hEE, 8'hEE);
                mem_write_en = 1'b1;
            end
            #1;
            check_eq($sformatf("dmp_vld%0d", i), {31'b0, dump_valid}, 32'h1);
            check_eq($sformatf("dmp_adr%0d", i), {16'b0, dump_addr}, 32'h100 + exp_cnt);
            check_eq($sformatf("dmp_dat%0d", i), {24'b0, dump_data}, {24'b0, exp_b[exp_cnt]});
            check_eq($sformatf("dmp_dn%0d", i),  {31'b0, dump_done}, 32'h0);
            tick();
            if (pat[i]) exp_cnt++;
        end
        check_eq("done_set",  {31'b0, dump_done},  32'h1);
        check_eq("done_vld",  {31'b0, dump_valid}, 32'h0);
        check_eq("done_addr", {16'b0, dump_addr},  32'h0);
        check_eq("done_data", {24'b0, dump_data},  32'h0);
        tick(); tick();
        mem_write_en = 1'b0;
        dump_ready = 1'b0;
        inst_addr = 32'h100;
        #1;
        check_eq("done_stick", {31'b0, dump_done}, 32'h1);
        check_eq("nowr_dump",  inst, 32'h44332211);

        // Reset mid-dump, then restart from the base.
        rst_b = 1'b0;
        #2;
        rst_b = 1'b1;
        halted = 1'b1;
        dump_ready = 1'b1;
        tick();
        check_eq("rs_start", {16'b0, dump_addr}, 32'h100);
        tick(); tick();
        check_eq("rs_two", {16'b0, dump_addr}, 32'h102);
        rst_b = 1'b0;
        #1;
        check_eq("rs_vld0",  {31'b0, dump_valid}, 32'h0);
        check_eq("rs_done0", {31'b0, dump_done},  32'h0);
        check_eq("rs_addr0", {16'b0, dump_addr},  32'h0);
        #1;
        rst_b = 1'b1;
        tick();
        check_eq("re_vld",  {31'b0, dump_valid}, 32'h1);
        check_eq("re_addr", {16'b0, dump_addr},  32'h100);
        check_eq("re_data", {24'b0, dump_data},  32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
